// File: rtl/ro_puf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_sequencer
// Brief    : Control FSM for an NBITS-wide ring-oscillator PUF array.
//            Latches a challenge, clears the array, runs the race until every
//            bit finishes or a timeout expires, captures the response and
//            offers it on a valid/ready handshake.
// Options  : define PUF_MAJORITY_VOTE_EN to run VOTES passes per request
//            and resolve each response bit by majority.
// Revision : 1.0 - initial release
// ============================================================================
module ro_puf_sequencer #(
   parameter int NBITS          = 8,
   parameter int CLR_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int VOTES          = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [7:0]       challenge_i,
   output logic [7:0]       puf_challenge_o,
   output logic             puf_rst_o,
   output logic             puf_ena_o,
   input  logic [NBITS-1:0] puf_resp_i,
   input  logic [NBITS-1:0] puf_finish_i,
   output logic [NBITS-1:0] resp_o,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_timeout_o,
   output logic             busy_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

   // Parameter sanity: odd vote count, at least one clear and one run cycle
   if ((CLR_CYCLES < 1) || (TIMEOUT_CYCLES < 1) || (VOTES < 1) || ((VOTES % 2) == 0)) begin : g_param_check
      $error("ro_puf_sequencer: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_RUN     = 3'd2,
      S_CAPTURE = 3'd3,
      S_HOLD    = 3'd4
   } state_e;

   state_e            state_q;
   logic [7:0]        puf_challenge_q;
   logic              puf_rst_q;
   logic              puf_ena_q;
   logic [NBITS-1:0]  resp_q;
   logic              resp_valid_q;
   logic              resp_timeout_q;
   logic              busy_q;
   logic [CLR_W-1:0]  clr_cnt_q;
   logic [CNT_W-1:0]  run_cnt_q;

   logic              start_accept_d;
   logic              capture_d;
   logic              all_finished_d;
   logic              last_pass_d;
   logic [NBITS-1:0]  vote_resp_d;

   assign start_accept_d = (state_q == S_IDLE) && start_i;
   assign capture_d      = (state_q == S_CAPTURE);
   assign all_finished_d = &puf_finish_i;

`ifdef PUF_MAJORITY_VOTE_EN
   localparam int VCNT_W = $clog2(VOTES + 1);
   localparam int SUM_W  = VCNT_W + 1;
   localparam int PASS_W = $clog2(VOTES + 1);
   localparam logic [SUM_W-1:0]  HALF      = SUM_W'(VOTES / 2);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(VOTES - 1);

   logic [PASS_W-1:0] pass_q;

   // Track which pass of the current request is being evaluated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_q <= '0;
      end else if (start_accept_d) begin
         pass_q <= '0;
      end else if (capture_d && !last_pass_d) begin
         pass_q <= pass_q + PASS_W'(1);
      end
   end

   assign last_pass_d = (pass_q == PASS_LAST);

   for (genvar g = 0; g < NBITS; g++) begin : g_vote_bit
      logic [VCNT_W-1:0] cnt_q;

      // Count the passes in which this bit resolved to 1
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (start_accept_d) begin
            cnt_q <= '0;
         end else if (capture_d && puf_resp_i[g]) begin
            cnt_q <= cnt_q + VCNT_W'(1);
         end
      end

      // Majority includes the sample being captured on the final pass
      assign vote_resp_d[g] = ({1'b0, cnt_q} + SUM_W'(puf_resp_i[g])) > HALF;
   end
`else
   // Single pass: the captured sample is the response
   assign last_pass_d = 1'b1;
   assign vote_resp_d = puf_resp_i;
`endif

   // Sequencer FSM with all array and handshake outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         puf_challenge_q <= '0;
         puf_rst_q       <= 1'b0;
         puf_ena_q       <= 1'b0;
         resp_q          <= '0;
         resp_valid_q    <= 1'b0;
         resp_timeout_q  <= 1'b0;
         busy_q          <= 1'b0;
         clr_cnt_q       <= '0;
         run_cnt_q       <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q         <= S_CLEAR;
                  puf_challenge_q <= challenge_i;
                  puf_rst_q       <= 1'b1;
                  busy_q          <= 1'b1;
                  resp_timeout_q  <= 1'b0;
                  clr_cnt_q       <= '0;
               end
            end
            S_CLEAR: begin
               if (clr_cnt_q == CLR_LAST) begin
                  state_q   <= S_RUN;
                  puf_rst_q <= 1'b0;
                  puf_ena_q <= 1'b1;
                  run_cnt_q <= '0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + CLR_W'(1);
               end
            end
            S_RUN: begin
               // A finish coinciding with the last allowed cycle is a normal finish
               if (all_finished_d || (run_cnt_q == RUN_LAST)) begin
                  state_q   <= S_CAPTURE;
                  puf_ena_q <= 1'b0;
                  if (!all_finished_d) begin
                     resp_timeout_q <= 1'b1;
                  end
               end else begin
                  run_cnt_q <= run_cnt_q + CNT_W'(1);
               end
            end
            S_CAPTURE: begin
               if (last_pass_d) begin
                  state_q      <= S_HOLD;
                  resp_q       <= vote_resp_d;
                  resp_valid_q <= 1'b1;
               end else begin
                  state_q   <= S_CLEAR;
                  puf_rst_q <= 1'b1;
                  clr_cnt_q <= '0;
               end
            end
            S_HOLD: begin
               if (resp_ready_i) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign puf_challenge_o = puf_challenge_q;
   assign puf_rst_o       = puf_rst_q;
   assign puf_ena_o       = puf_ena_q;
   assign resp_o          = resp_q;
   assign resp_valid_o    = resp_valid_q;
   assign resp_timeout_o  = resp_timeout_q;
   assign busy_o          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ro_puf_sequencer
// Brief    : Self-checking bench for ro_puf_sequencer. A per-request timeline
//            (clear/run/capture cycles) is built from the protocol rules and
//            every DUT output is compared against it cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ro_puf_sequencer;

   localparam int NB    = 8;
   localparam int CLR   = 4;
   localparam int TO    = 1023;
   localparam int VOTES = 5;
   localparam int MAXT  = 8192;
   localparam int NEVER = 100000;
`ifdef PUF_MAJORITY_VOTE_EN
   localparam int PASSES = VOTES;
`else
   localparam int PASSES = 1;
`endif
   localparam logic [4:0] PAT0 = 5'b01101;
   localparam logic [4:0] PAT1 = 5'b10100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    challenge = '0;
   logic [7:0]    puf_challenge;
   logic          puf_rst;
   logic          puf_ena;
   logic [NB-1:0] puf_resp = '0;
   logic [NB-1:0] puf_finish = '0;
   logic [NB-1:0] resp;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic          resp_timeout;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   bit exp_rst [MAXT];
   bit exp_ena [MAXT];
   bit capt    [MAXT];
   int runk    [MAXT];
   int runr    [MAXT];
   int rlen    [VOTES];

   ro_puf_sequencer #(
      .NBITS(NB), .CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TO), .VOTES(VOTES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .challenge_i(challenge),
      .puf_challenge_o(puf_challenge), .puf_rst_o(puf_rst), .puf_ena_o(puf_ena),
      .puf_resp_i(puf_resp), .puf_finish_i(puf_finish), .resp_o(resp),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_timeout_o(resp_timeout), .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NB-1:0] partial_finish();
      logic [NB-1:0] v;
      v = NB'($urandom);
      v[$urandom_range(0, NB - 1)] = 1'b0;
      return v;
   endfunction

   // One complete request: start, PASSES evaluations, hold for 'hold' cycles, ack
   task automatic do_request(input logic [7:0] ch, input int hold, input bit force01);
      int t, tv, rl_eff, pidx, rises;
      bit exp_to, prev_rst;
      int ones [NB];
      logic [NB-1:0] smp, exp_resp;
      for (int i = 0; i < MAXT; i++) begin
         exp_rst[i] = 0; exp_ena[i] = 0; capt[i] = 0; runk[i] = 0; runr[i] = 0;
      end
      t = 1;
      exp_to = 0;
      for (int p = 0; p < PASSES; p++) begin
         for (int c = 0; c < CLR; c++) begin
            exp_rst[t] = 1; t++;
         end
         rl_eff = (rlen[p] < TO) ? rlen[p] : TO;
         if (rlen[p] > TO) exp_to = 1;
         for (int k = 1; k <= rl_eff; k++) begin
            exp_ena[t] = 1; runk[t] = k; runr[t] = rlen[p]; t++;
         end
         capt[t] = 1; t++;
      end
      tv = t;
      for (int i = 0; i < NB; i++) ones[i] = 0;
      pidx = 0; rises = 0; prev_rst = 0;

      // t = 0: the accepting IDLE cycle
      @(posedge clk); #1;
      start = 1'b1; challenge = ch; puf_resp = NB'($urandom);
      puf_finish = NB'($urandom); resp_ready = 1'($urandom);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rst", 32'(puf_rst), 32'd0);

      for (t = 1; t < tv; t++) begin
         @(posedge clk); #1;
         start = 1'($urandom); challenge = 8'($urandom); resp_ready = 1'($urandom);
         smp = NB'($urandom);
         if (force01 && capt[t]) begin
            smp[0] = PAT0[pidx];
            smp[1] = PAT1[pidx];
         end
         puf_resp = smp;
         if (exp_ena[t]) begin
            if (runk[t] >= runr[t]) puf_finish = '1;
            else if (runr[t] > TO) puf_finish = 8'h7F;
            else puf_finish = partial_finish();
         end else begin
            puf_finish = NB'($urandom);
         end
         if (capt[t]) begin
            for (int i = 0; i < NB; i++) ones[i] += int'(smp[i]);
            pidx++;
         end
         @(negedge clk);
         check("puf_rst", 32'(puf_rst), 32'(exp_rst[t]));
         check("puf_ena", 32'(puf_ena), 32'(exp_ena[t]));
         check("busy", 32'(busy), 32'd1);
         check("valid_early", 32'(resp_valid), 32'd0);
         check("challenge", 32'(puf_challenge), 32'(ch));
         if (puf_rst && !prev_rst) rises++;
         prev_rst = puf_rst;
      end
      check("rst_pulses", 32'(rises), 32'(PASSES));

      for (int i = 0; i < NB; i++) exp_resp[i] = (ones[i] > PASSES / 2);

      // HOLD: ready low for 'hold' cycles, then ack with start also high
      for (int h = 0; h <= hold; h++) begin
         @(posedge clk); #1;
         resp_ready = (h == hold);
         start = (h == hold) ? 1'b1 : 1'($urandom);
         challenge = 8'($urandom); puf_resp = NB'($urandom); puf_finish = NB'($urandom);
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_resp", 32'(resp), 32'(exp_resp));
         check("hold_timeout", 32'(resp_timeout), 32'(exp_to));
         check("hold_busy", 32'(busy), 32'd1);
         check("hold_ena", 32'(puf_ena), 32'd0);
         check("hold_challenge", 32'(puf_challenge), 32'(ch));
      end
      @(posedge clk); #1;
      start = 1'b0; resp_ready = 1'($urandom);
      @(negedge clk);
      check("post_ack_valid", 32'(resp_valid), 32'd0);
      check("post_ack_busy", 32'(busy), 32'd0);
      check("post_ack_rst", 32'(puf_rst), 32'd0);
   endtask

   task automatic set_rlen_all(input int v);
      for (int p = 0; p < VOTES; p++) rlen[p] = v;
   endtask

   task automatic set_rlen_rand(input int lo, input int hi);
      for (int p = 0; p < VOTES; p++) rlen[p] = $urandom_range(lo, hi);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_resp", 32'(resp), 32'd0);
      check("rst_chal", 32'(puf_challenge), 32'd0);
      check("rst_puf_rst", 32'(puf_rst), 32'd0);
      check("rst_ena", 32'(puf_ena), 32'd0);
      check("rst_timeout", 32'(resp_timeout), 32'd0);
      rst_n = 1'b1;

      // T1: finish on RUN cycle 10, immediate ack
      set_rlen_all(10);
      do_request(8'hA5, 0, 1'b0);

      // T2: finish stuck at 7F -> timeout
      set_rlen_all(NEVER);
      do_request(8'($urandom), 2, 1'b0);

      // T3: long back-pressure with start/challenge toggling
      set_rlen_rand(1, 30);
      do_request(8'($urandom), 20, 1'b0);

      // T5: finish on the very cycle the counter reaches TIMEOUT-1
      set_rlen_all(TO);
      do_request(8'($urandom), 1, 1'b0);

      // Finished on the first RUN cycle
      set_rlen_all(1);
      do_request(8'($urandom), 0, 1'b0);

      // Mixed normal and timed-out passes (sticky timeout when voting)
      set_rlen_rand(1, 20);
      rlen[PASSES - 1] = NEVER;
      do_request(8'($urandom), 1, 1'b0);

      // Random requests
      for (int n = 0; n < 6; n++) begin
         set_rlen_rand(1, 40);
         do_request(8'($urandom), $urandom_range(0, 3), 1'b0);
      end

      // T6: forced bit0/bit1 pass patterns (majority in voting builds)
      set_rlen_rand(2, 12);
      do_request(8'h5A, 0, 1'b1);

      // T4: reset asserted in the middle of RUN
      @(posedge clk); #1;
      start = 1'b1; challenge = 8'h3C; puf_finish = '0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (CLR + 3) @(posedge clk);
      @(negedge clk);
      check("t4_in_run", 32'(puf_ena), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_ena", 32'(puf_ena), 32'd0);
      check("t4_valid", 32'(resp_valid), 32'd0);
      check("t4_resp", 32'(resp), 32'd0);
      check("t4_chal", 32'(puf_challenge), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t4_idle_busy", 32'(busy), 32'd0);
      set_rlen_rand(1, 15);
      do_request(8'hC3, 0, 1'b0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
